// File: rtl/analogue_acquisition_sequencer_if.sv
// Bundles the control, sample and buffer-write signals of the acquisition sequencer.
//   master : host / decimator side; drives arm, abort, lengths, samples and trigger,
//            and observes the buffer write port and status.
//   slave  : the sequencer itself.
// Signals:
//   arm, abort                 single-cycle start/re-arm and cancel requests
//   pretrig_len, posttrig_len  capture lengths, latched when an arm is accepted
//   sample_valid, sample_data  decimated sample stream
//   trigger                    trigger qualifier, meaningful only with sample_valid
//   dec_en                     decimator enable
//   wr_en, wr_addr, wr_data    capture RAM write port
//   trig_addr                  buffer address of the trigger sample
//   busy, done                 capture in progress / capture complete
interface analogue_acquisition_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  arm;
    logic                  abort;
    logic [ADDR_WIDTH-1:0] pretrig_len;
    logic [ADDR_WIDTH-1:0] posttrig_len;
    logic                  sample_valid;
    logic [DATA_WIDTH-1:0] sample_data;
    logic                  trigger;
    logic                  dec_en;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0] trig_addr;
    logic                  busy;
    logic                  done;

    modport master (
        output arm, abort, pretrig_len, posttrig_len, sample_valid, sample_data, trigger,
        input  dec_en, wr_en, wr_addr, wr_data, trig_addr, busy, done
    );

    modport slave (
        input  arm, abort, pretrig_len, posttrig_len, sample_valid, sample_data, trigger,
        output dec_en, wr_en, wr_addr, wr_data, trig_addr, busy, done
    );
endinterface

// File: rtl/analogue_acquisition_sequencer.sv
// Sequences one triggered capture into a circular sample buffer: fills a pre-trigger
// region, honours the first trigger after that fill, writes the post-trigger samples
// and stops with the buffer stable until re-armed.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  slave side of analogue_acquisition_sequencer_if (control, samples, RAM writes)
// All outputs are registered; a sample accepted in cycle N is written in cycle N+1.
module analogue_acquisition_sequencer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    analogue_acquisition_sequencer_if.slave bus
);
    localparam int unsigned CntWidth = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {StIdle, StPre, StArmed, StPost, StDone} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    // One counter serves both the pre-trigger and the post-trigger phase.
    logic [CntWidth-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [ADDR_WIDTH-1:0] pre_len_q, pre_len_d;
    logic [ADDR_WIDTH-1:0] post_len_q, post_len_d;
    logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  wr_en_q, wr_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        pre_len_d   = pre_len_q;
        post_len_d  = post_len_q;
        trig_addr_d = trig_addr_q;
        wr_en_d     = 1'b0;

        if (bus.abort) begin
            // Abort wins over everything, including a sample arriving this cycle.
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (state_q == StIdle) begin
                        ptr_d = '0;
                        cnt_d = '0;
                    end
                    if (bus.arm) begin
                        ptr_d      = '0;
                        cnt_d      = '0;
                        pre_len_d  = bus.pretrig_len;
                        post_len_d = bus.posttrig_len;
                        state_d    = (bus.pretrig_len == '0) ? StArmed : StPre;
                    end
                end
                StPre: begin
                    // Trigger is deliberately ignored until the pre-trigger fill completes.
                    if (bus.sample_valid) begin
                        wr_en_d = 1'b1;
                        ptr_d   = ptr_q + 1'b1;
                        cnt_d   = cnt_inc;
                        if (cnt_inc == {1'b0, pre_len_q}) begin
                            cnt_d   = '0;
                            state_d = StArmed;
                        end
                    end
                end
                StArmed: begin
                    if (bus.sample_valid) begin
                        wr_en_d = 1'b1;
                        ptr_d   = ptr_q + 1'b1;
                        if (bus.trigger) begin
                            trig_addr_d = ptr_q;
                            cnt_d       = '0;
                            state_d     = (post_len_q == '0) ? StDone : StPost;
                        end
                    end
                end
                StPost: begin
                    if (bus.sample_valid) begin
                        wr_en_d = 1'b1;
                        ptr_d   = ptr_q + 1'b1;
                        cnt_d   = cnt_inc;
                        if (cnt_inc == {1'b0, post_len_q}) begin
                            state_d = StDone;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        busy_d = (state_d == StPre) || (state_d == StArmed) || (state_d == StPost);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            cnt_q       <= '0;
            pre_len_q   <= '0;
            post_len_q  <= '0;
            trig_addr_q <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            pre_len_q   <= pre_len_d;
            post_len_q  <= post_len_d;
            trig_addr_q <= trig_addr_d;
            wr_en_q     <= wr_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            // Address/data hold their last written value between writes.
            if (wr_en_d) begin
                wr_addr_q <= ptr_q;
                wr_data_q <= bus.sample_data;
            end
        end
    end

    assign bus.dec_en    = busy_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.trig_addr = trig_addr_q;
endmodule

// File: tb/tb_analogue_acquisition_sequencer.sv
// Self-checking bench for analogue_acquisition_sequencer (ADDR_WIDTH=4, DATA_WIDTH=8).
// The reference model tracks a capture as "k-th sample since arm": sample k lands at
// address k mod depth, the trigger is honoured on the first triggered sample with
// k >= pre, and the capture ends once pre-trigger index + post samples are written.
module tb_analogue_acquisition_sequencer;
    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int          DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    analogue_acquisition_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

    analogue_acquisition_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit          m_run = 1'b0;
    int          m_k   = 0;
    int          m_tk  = -1;
    int          m_pre = 0;
    int          m_post = 0;
    logic [AW-1:0] m_trig_addr = '0;
    bit          exp_wr, exp_busy, exp_done;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;

    function automatic bit m_capturing();
        return m_run && !(m_tk >= 0 && m_k > m_tk + m_post);
    endfunction

    // Drives one clock cycle of inputs, advances the model, returns #1 after the edge.
    task automatic step(input bit a, input bit ab, input bit sv, input bit tg,
                        input logic [DW-1:0] d);
        bus_if.arm          = a;
        bus_if.abort        = ab;
        bus_if.sample_valid = sv;
        bus_if.trigger      = tg;
        bus_if.sample_data  = d;
        exp_wr = 1'b0;
        if (rst) begin
            m_run       = 1'b0;
            m_trig_addr = '0;
        end else if (ab) begin
            m_run = 1'b0;
        end else if (m_capturing()) begin
            if (sv) begin
                exp_wr   = 1'b1;
                exp_addr = AW'(m_k % DEPTH);
                exp_data = d;
                if (m_tk < 0 && m_k >= m_pre && tg) begin
                    m_tk        = m_k;
                    m_trig_addr = AW'(m_k % DEPTH);
                end
                m_k++;
            end
        end else if (a) begin
            m_run  = 1'b1;
            m_k    = 0;
            m_tk   = -1;
            m_pre  = int'(bus_if.pretrig_len);
            m_post = int'(bus_if.posttrig_len);
        end
        @(posedge clk);
        #1;
        bus_if.arm          = 1'b0;
        bus_if.abort        = 1'b0;
        bus_if.sample_valid = 1'b0;
        bus_if.trigger      = 1'b0;
        exp_busy = m_capturing();
        exp_done = m_run && !m_capturing();
    endtask

    task automatic test_reset();
        step(0, 0, 0, 0, '0);
        step(0, 0, 0, 0, '0);
        checks++;
        if ({bus_if.dec_en, bus_if.wr_en, bus_if.wr_addr, bus_if.wr_data, bus_if.trig_addr,
             bus_if.busy, bus_if.done} !== '0) begin
            failures++;
            $display("FAIL reset_values got dec/wr/addr/data/trig/busy/done=%b want all 0",
                     {bus_if.dec_en, bus_if.wr_en, bus_if.wr_addr, bus_if.wr_data,
                      bus_if.trig_addr, bus_if.busy, bus_if.done});
        end
        rst = 1'b0;
        bus_if.pretrig_len  = 4'd2;
        bus_if.posttrig_len = 4'd15;
        step(1, 0, 0, 0, '0);
        // 37 samples: pointer is 37 (5 at this depth), last write was sample 36 -> addr 4.
        for (int i = 0; i < 37; i++) step(0, 0, 1, 0, DW'($urandom));
        checks++;
        if (bus_if.busy !== 1'b1 || bus_if.wr_addr !== 4'd4) begin
            failures++;
            $display("FAIL reset_midcap_setup got busy=%b wr_addr=%0d want busy=1 wr_addr=4",
                     bus_if.busy, bus_if.wr_addr);
        end
        rst = 1'b1;
        step(0, 0, 1, 1, 8'h5a);
        checks++;
        if ({bus_if.dec_en, bus_if.wr_en, bus_if.wr_addr, bus_if.wr_data, bus_if.trig_addr,
             bus_if.busy, bus_if.done} !== '0) begin
            failures++;
            $display("FAIL reset_midcap got outputs=%b want all 0",
                     {bus_if.dec_en, bus_if.wr_en, bus_if.wr_addr, bus_if.wr_data,
                      bus_if.trig_addr, bus_if.busy, bus_if.done});
        end
        rst = 1'b0;
        bus_if.pretrig_len = 4'd3;
        step(1, 0, 0, 0, '0);
        step(0, 0, 1, 0, 8'h77);
        checks++;
        if (bus_if.wr_en !== 1'b1 || bus_if.wr_addr !== 4'd0 || bus_if.wr_data !== 8'h77) begin
            failures++;
            $display("FAIL reset_restart got wr_en=%b addr=%0d data=%h want 1 0 77",
                     bus_if.wr_en, bus_if.wr_addr, bus_if.wr_data);
        end
        step(0, 1, 0, 0, '0);
    endtask

    task automatic test_holdoff();
        int n_wr = 0;
        bit done_seen = 1'b0;
        logic done_wr = 1'b0;
        logic [AW-1:0] done_addr = '0;
        bus_if.pretrig_len  = 4'd4;
        bus_if.posttrig_len = 4'd3;
        step(1, 0, 0, 0, '0);
        checks++;
        if ({bus_if.dec_en, bus_if.busy, bus_if.wr_en, bus_if.done} !== 4'b1100) begin
            failures++;
            $display("FAIL holdoff_arm got dec/busy/wr/done=%b want 1100",
                     {bus_if.dec_en, bus_if.busy, bus_if.wr_en, bus_if.done});
        end
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 1, (i == 2 || i == 6), DW'(8'h10 + i));
            checks++;
            if ({bus_if.dec_en, bus_if.busy, bus_if.done, bus_if.wr_en} !==
                {exp_busy, exp_busy, exp_done, exp_wr}) begin
                failures++;
                $display("FAIL holdoff_ctl i=%0d got dec/busy/done/wr=%b want %b", i,
                         {bus_if.dec_en, bus_if.busy, bus_if.done, bus_if.wr_en},
                         {exp_busy, exp_busy, exp_done, exp_wr});
            end
            checks++;
            if (bus_if.trig_addr !== m_trig_addr) begin
                failures++;
                $display("FAIL holdoff_trig i=%0d got %0d want %0d", i, bus_if.trig_addr,
                         m_trig_addr);
            end
            if (exp_wr) begin
                checks++;
                if ({bus_if.wr_addr, bus_if.wr_data} !== {exp_addr, exp_data}) begin
                    failures++;
                    $display("FAIL holdoff_wr i=%0d got %0d/%h want %0d/%h", i,
                             bus_if.wr_addr, bus_if.wr_data, exp_addr, exp_data);
                end
            end
            if (bus_if.wr_en === 1'b1) n_wr++;
            if (bus_if.done === 1'b1 && !done_seen) begin
                done_seen = 1'b1;
                done_wr   = bus_if.wr_en;
                done_addr = bus_if.wr_addr;
            end
        end
        checks++;
        if (n_wr != 10 || bus_if.trig_addr !== 4'd6 || done_wr !== 1'b1 || done_addr !== 4'd9)
        begin
            failures++;
            $display("FAIL holdoff_summary got writes=%0d trig=%0d done_wr=%b done_addr=%0d want 10 6 1 9",
                     n_wr, bus_if.trig_addr, done_wr, done_addr);
        end
    endtask

    task automatic test_wrap();
        bit wrapped = 1'b0;
        logic [AW-1:0] prev = '0;
        logic [AW-1:0] last_addr = '0;
        int n_wr = 0;
        bus_if.pretrig_len  = 4'd2;
        bus_if.posttrig_len = 4'd5;
        step(1, 0, 0, 0, '0);
        for (int i = 0; i < 30; i++) begin
            step(0, 0, 1, (i == 20), DW'($urandom));
            checks++;
            if ({bus_if.busy, bus_if.done, bus_if.wr_en} !== {exp_busy, exp_done, exp_wr}) begin
                failures++;
                $display("FAIL wrap_ctl i=%0d got busy/done/wr=%b want %b", i,
                         {bus_if.busy, bus_if.done, bus_if.wr_en}, {exp_busy, exp_done, exp_wr});
            end
            if (exp_wr) begin
                checks++;
                if ({bus_if.wr_addr, bus_if.wr_data} !== {exp_addr, exp_data}) begin
                    failures++;
                    $display("FAIL wrap_wr i=%0d got %0d/%h want %0d/%h", i,
                             bus_if.wr_addr, bus_if.wr_data, exp_addr, exp_data);
                end
            end
            if (bus_if.wr_en === 1'b1) begin
                if (n_wr > 0 && prev == 4'd15 && bus_if.wr_addr == 4'd0) wrapped = 1'b1;
                prev      = bus_if.wr_addr;
                last_addr = bus_if.wr_addr;
                n_wr++;
            end
        end
        checks++;
        if (!wrapped || n_wr != 26 || bus_if.trig_addr !== 4'd4 || last_addr !== 4'd9 ||
            bus_if.done !== 1'b1) begin
            failures++;
            $display("FAIL wrap_summary got wrapped=%0d writes=%0d trig=%0d last=%0d done=%b want 1 26 4 9 1",
                     wrapped, n_wr, bus_if.trig_addr, last_addr, bus_if.done);
        end
    endtask

    task automatic test_zero_len();
        bus_if.pretrig_len  = 4'd0;
        bus_if.posttrig_len = 4'd0;
        step(1, 0, 0, 0, '0);
        step(0, 0, 1, 1, 8'ha5);
        checks++;
        if ({bus_if.wr_en, bus_if.wr_addr, bus_if.wr_data, bus_if.trig_addr, bus_if.done,
             bus_if.busy} !== {1'b1, 4'd0, 8'ha5, 4'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL zero_len got wr=%b addr=%0d data=%h trig=%0d done=%b busy=%b want 1 0 a5 0 1 0",
                     bus_if.wr_en, bus_if.wr_addr, bus_if.wr_data, bus_if.trig_addr,
                     bus_if.done, bus_if.busy);
        end
        step(0, 0, 1, 1, 8'h3c);
        checks++;
        if (bus_if.wr_en !== 1'b0 || bus_if.done !== 1'b1) begin
            failures++;
            $display("FAIL zero_len_hold got wr=%b done=%b want 0 1", bus_if.wr_en, bus_if.done);
        end
    endtask

    task automatic test_abort();
        bus_if.pretrig_len  = 4'd1;
        bus_if.posttrig_len = 4'd3;
        step(1, 0, 0, 0, '0);
        step(0, 0, 1, 0, 8'h11);
        // Now armed with pointer 1; a trigger here would move trig_addr to 1.
        step(1, 1, 1, 1, 8'h22);
        checks++;
        if ({bus_if.wr_en, bus_if.busy, bus_if.dec_en, bus_if.done, bus_if.trig_addr} !==
            {1'b0, 1'b0, 1'b0, 1'b0, 4'd0}) begin
            failures++;
            $display("FAIL abort got wr/busy/dec/done=%b trig=%0d want 0000 trig=0",
                     {bus_if.wr_en, bus_if.busy, bus_if.dec_en, bus_if.done}, bus_if.trig_addr);
        end
        step(0, 0, 1, 1, 8'h33);
        checks++;
        if (bus_if.wr_en !== 1'b0 || bus_if.busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle got wr=%b busy=%b want 0 0", bus_if.wr_en, bus_if.busy);
        end
    endtask

    task automatic test_back_to_back_rearm();
        bus_if.pretrig_len  = 4'd1;
        bus_if.posttrig_len = 4'd2;
        step(1, 0, 0, 0, '0);
        step(0, 0, 1, 0, 8'h40);
        step(0, 0, 1, 1, 8'h41);
        bus_if.pretrig_len  = 4'd7;
        bus_if.posttrig_len = 4'd9;
        step(1, 0, 1, 0, 8'h42);
        step(0, 0, 1, 0, 8'h43);
        checks++;
        if ({bus_if.done, bus_if.busy, bus_if.wr_en, bus_if.wr_addr, bus_if.trig_addr} !==
            {1'b1, 1'b0, 1'b1, 4'd3, 4'd1}) begin
            failures++;
            $display("FAIL rearm_first got done/busy/wr=%b addr=%0d trig=%0d want 101 3 1",
                     {bus_if.done, bus_if.busy, bus_if.wr_en}, bus_if.wr_addr, bus_if.trig_addr);
        end
        bus_if.pretrig_len  = 4'd0;
        bus_if.posttrig_len = 4'd1;
        step(1, 0, 0, 0, '0);
        checks++;
        if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b1) begin
            failures++;
            $display("FAIL rearm_start got done=%b busy=%b want 0 1", bus_if.done, bus_if.busy);
        end
        step(0, 0, 1, 1, 8'h50);
        step(0, 0, 1, 0, 8'h51);
        checks++;
        if ({bus_if.wr_en, bus_if.wr_addr, bus_if.wr_data, bus_if.trig_addr, bus_if.done} !==
            {1'b1, 4'd1, 8'h51, 4'd0, 1'b1}) begin
            failures++;
            $display("FAIL rearm_second got wr=%b addr=%0d data=%h trig=%0d done=%b want 1 1 51 0 1",
                     bus_if.wr_en, bus_if.wr_addr, bus_if.wr_data, bus_if.trig_addr, bus_if.done);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 25; c++) begin
            bus_if.pretrig_len  = AW'($urandom_range(0, 6));
            bus_if.posttrig_len = AW'($urandom_range(0, 6));
            step(1, 0, 0, 0, '0);
            for (int i = 0; i < 40; i++) begin
                if ($urandom_range(0, 9) == 0) begin
                    bus_if.pretrig_len  = AW'($urandom);
                    bus_if.posttrig_len = AW'($urandom);
                end
                step(($urandom_range(0, 29) == 0), ($urandom_range(0, 59) == 0),
                     ($urandom_range(0, 9) < 7), ($urandom_range(0, 4) == 0), DW'($urandom));
                checks++;
                if ({bus_if.dec_en, bus_if.busy, bus_if.done, bus_if.wr_en} !==
                    {exp_busy, exp_busy, exp_done, exp_wr}) begin
                    failures++;
                    $display("FAIL random_ctl c=%0d i=%0d got dec/busy/done/wr=%b want %b", c, i,
                             {bus_if.dec_en, bus_if.busy, bus_if.done, bus_if.wr_en},
                             {exp_busy, exp_busy, exp_done, exp_wr});
                end
                checks++;
                if (bus_if.trig_addr !== m_trig_addr) begin
                    failures++;
                    $display("FAIL random_trig c=%0d i=%0d got %0d want %0d", c, i,
                             bus_if.trig_addr, m_trig_addr);
                end
                if (exp_wr) begin
                    checks++;
                    if ({bus_if.wr_addr, bus_if.wr_data} !== {exp_addr, exp_data}) begin
                        failures++;
                        $display("FAIL random_wr c=%0d i=%0d got %0d/%h want %0d/%h", c, i,
                                 bus_if.wr_addr, bus_if.wr_data, exp_addr, exp_data);
                    end
                end
            end
        end
    endtask

    initial begin
        bus_if.arm          = 1'b0;
        bus_if.abort        = 1'b0;
        bus_if.pretrig_len  = '0;
        bus_if.posttrig_len = '0;
        bus_if.sample_valid = 1'b0;
        bus_if.sample_data  = '0;
        bus_if.trigger      = 1'b0;
        test_reset();
        test_holdoff();
        test_wrap();
        test_zero_len();
        test_abort();
        test_back_to_back_rearm();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
